// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational 32-bit ALU between two requesters.
// Each requester gets a registered result slot and its own private NZCV register.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_ctrl,
    input  logic             req0_setflags,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_ctrl,
    input  logic             req1_setflags,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic [3:0]       rsp0_flags,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic [3:0]       rsp1_flags
);

    logic             rr_ptr_q,      rr_ptr_d;
    logic             rsp0_valid_q,  rsp0_valid_d;
    logic             rsp1_valid_q,  rsp1_valid_d;
    logic [WIDTH-1:0] rsp0_result_q, rsp0_result_d;
    logic [WIDTH-1:0] rsp1_result_q, rsp1_result_d;
    logic [3:0]       rsp0_flags_q,  rsp0_flags_d;
    logic [3:0]       rsp1_flags_q,  rsp1_flags_d;

    logic       elig0_s, elig1_s;
    logic       grant0_s, grant1_s;
    logic [1:0] grant_sel_s;

    // Eligibility and round-robin grant; reset masks both grants combinationally.
    always_comb begin
        elig0_s  = req0_valid & (~rsp0_valid_q | rsp0_ready) & ~reset;
        elig1_s  = req1_valid & (~rsp1_valid_q | rsp1_ready) & ~reset;
        grant0_s = elig0_s & (~elig1_s | ~rr_ptr_q);
        grant1_s = elig1_s & (~elig0_s |  rr_ptr_q);
        grant_sel_s = {grant1_s, grant0_s};
    end

    // Shared ALU operand mux, idle value zero.
    always_comb begin
        alu_a    = {WIDTH{1'b0}};
        alu_b    = {WIDTH{1'b0}};
        alu_ctrl = 2'b00;
        case (grant_sel_s)
            2'b01: begin
                alu_a    = req0_a;
                alu_b    = req0_b;
                alu_ctrl = req0_ctrl;
            end
            2'b10: begin
                alu_a    = req1_a;
                alu_b    = req1_b;
                alu_ctrl = req1_ctrl;
            end
            default: begin
                alu_a    = {WIDTH{1'b0}};
                alu_b    = {WIDTH{1'b0}};
                alu_ctrl = 2'b00;
            end
        endcase
    end

    // Next-state: pointer update and per-requester response slots.
    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        rsp0_valid_d  = rsp0_valid_q;
        rsp1_valid_d  = rsp1_valid_q;
        rsp0_result_d = rsp0_result_q;
        rsp1_result_d = rsp1_result_q;
        rsp0_flags_d  = rsp0_flags_q;
        rsp1_flags_d  = rsp1_flags_q;

        if (grant0_s) begin
            rr_ptr_d = 1'b1;
        end else if (grant1_s) begin
            rr_ptr_d = 1'b0;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end

        // An accept wins over a same-cycle drain, keeping the slot full.
        if (grant0_s) begin
            rsp0_valid_d  = 1'b1;
            rsp0_result_d = alu_result;
            if (req0_setflags) begin
                rsp0_flags_d = alu_flags;
            end else begin
                rsp0_flags_d = rsp0_flags_q;
            end
        end else if (rsp0_valid_q & rsp0_ready) begin
            rsp0_valid_d = 1'b0;
        end else begin
            rsp0_valid_d = rsp0_valid_q;
        end

        if (grant1_s) begin
            rsp1_valid_d  = 1'b1;
            rsp1_result_d = alu_result;
            if (req1_setflags) begin
                rsp1_flags_d = alu_flags;
            end else begin
                rsp1_flags_d = rsp1_flags_q;
            end
        end else if (rsp1_valid_q & rsp1_ready) begin
            rsp1_valid_d = 1'b0;
        end else begin
            rsp1_valid_d = rsp1_valid_q;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q      <= 1'b0;
            rsp0_valid_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp0_result_q <= {WIDTH{1'b0}};
            rsp1_result_q <= {WIDTH{1'b0}};
            rsp0_flags_q  <= 4'b0000;
            rsp1_flags_q  <= 4'b0000;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            rsp0_valid_q  <= rsp0_valid_d;
            rsp1_valid_q  <= rsp1_valid_d;
            rsp0_result_q <= rsp0_result_d;
            rsp1_result_q <= rsp1_result_d;
            rsp0_flags_q  <= rsp0_flags_d;
            rsp1_flags_q  <= rsp1_flags_d;
        end
    end

    assign req0_ready  = grant0_s;
    assign req1_ready  = grant1_s;
    assign rsp0_valid  = rsp0_valid_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp0_result = rsp0_result_q;
    assign rsp1_result = rsp1_result_q;
    assign rsp0_flags  = rsp0_flags_q;
    assign rsp1_flags  = rsp1_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: behavioural ALU, transaction-level
// reference model, directed scenarios followed by random traffic.
module tb_alu_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]  req0_ctrl, req1_ctrl;
    logic        req0_setflags, req1_setflags;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [1:0]  alu_ctrl;
    logic [3:0]  alu_flags;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_result, rsp1_result;
    logic [3:0]  rsp0_flags, rsp1_flags;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit          m_v0, m_v1;
    logic [31:0] m_r0, m_r1;
    logic [3:0]  m_f0, m_f1;
    int          m_last;
    int          last_g;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
        .req0_setflags(req0_setflags),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
        .req1_setflags(req1_setflags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags)
    );

    // Reference ALU: returns {result, N, Z, C, V}; C is carry-out / not-borrow.
    function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] c);
        logic [32:0] s;
        logic [31:0] r;
        logic        cf, vf;
        cf = 1'b0; vf = 1'b0;
        case (c)
            2'b00: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0]; cf = s[32];
                vf = (a[31] == b[31]) && (r[31] != a[31]);
            end
            2'b01: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0]; cf = s[32];
                vf = (a[31] != b[31]) && (r[31] != a[31]);
            end
            2'b10:   r = a & b;
            default: r = a | b;
        endcase
        return {r, r[31], (r == 32'd0), cf, vf};
    endfunction

    always_comb {alu_result, alu_flags} = alu_ref(alu_a, alu_b, alu_ctrl);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_v0 = 0; m_v1 = 0; m_r0 = 32'd0; m_r1 = 32'd0;
        m_f0 = 4'd0; m_f1 = 4'd0; m_last = 1;
    endtask

    // One clock cycle: called just after a negedge with inputs already driven.
    task automatic cycle();
        int g;
        bit e0, e1;
        logic [35:0] o;
        #1;
        e0 = req0_valid && (!m_v0 || rsp0_ready);
        e1 = req1_valid && (!m_v1 || rsp1_ready);
        if (e0 && e1) g = (m_last == 0) ? 1 : 0;
        else if (e0)  g = 0;
        else if (e1)  g = 1;
        else          g = -1;
        chk("req0_ready", {63'd0, req0_ready}, {63'd0, g == 0});
        chk("req1_ready", {63'd0, req1_ready}, {63'd0, g == 1});
        chk("alu_a",    {32'd0, alu_a},    {32'd0, g == 0 ? req0_a : g == 1 ? req1_a : 32'd0});
        chk("alu_b",    {32'd0, alu_b},    {32'd0, g == 0 ? req0_b : g == 1 ? req1_b : 32'd0});
        chk("alu_ctrl", {62'd0, alu_ctrl}, {62'd0, g == 0 ? req0_ctrl : g == 1 ? req1_ctrl : 2'b00});
        @(posedge clk);
        if (g == 0) begin
            o = alu_ref(req0_a, req0_b, req0_ctrl);
            m_v0 = 1; m_r0 = o[35:4];
            if (req0_setflags) m_f0 = o[3:0];
        end else if (m_v0 && rsp0_ready) m_v0 = 0;
        if (g == 1) begin
            o = alu_ref(req1_a, req1_b, req1_ctrl);
            m_v1 = 1; m_r1 = o[35:4];
            if (req1_setflags) m_f1 = o[3:0];
        end else if (m_v1 && rsp1_ready) m_v1 = 0;
        if (g >= 0) m_last = g;
        last_g = g;
        @(negedge clk);
        chk("rsp0_valid",  {63'd0, rsp0_valid},  {63'd0, m_v0});
        chk("rsp1_valid",  {63'd0, rsp1_valid},  {63'd0, m_v1});
        chk("rsp0_result", {32'd0, rsp0_result}, {32'd0, m_r0});
        chk("rsp1_result", {32'd0, rsp1_result}, {32'd0, m_r1});
        chk("rsp0_flags",  {60'd0, rsp0_flags},  {60'd0, m_f0});
        chk("rsp1_flags",  {60'd0, rsp1_flags},  {60'd0, m_f1});
    endtask

    task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] c, input logic s);
        req0_valid = v; req0_a = a; req0_b = b; req0_ctrl = c; req0_setflags = s;
    endtask

    task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] c, input logic s);
        req1_valid = v; req1_a = a; req1_b = b; req1_ctrl = c; req1_setflags = s;
    endtask

    initial begin
        int exp_g;
        model_reset();
        last_g = -1;
        reset = 1'b1;
        set0(1'b1, 32'd1, 32'd1, 2'b00, 1'b1);
        set1(1'b1, 32'd1, 32'd1, 2'b00, 1'b1);
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready0", {63'd0, req0_ready}, 64'd0);
        chk("rst_ready1", {63'd0, req1_ready}, 64'd0);
        chk("rst_v0", {63'd0, rsp0_valid}, 64'd0);
        chk("rst_res1", {32'd0, rsp1_result}, 64'd0);
        chk("rst_fl0", {60'd0, rsp0_flags}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // single add
        set0(1'b1, 32'd5, 32'd3, 2'b00, 1'b1);
        set1(1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
        cycle();
        chk("add_res", {32'd0, rsp0_result}, 64'd8);
        chk("add_fl",  {60'd0, rsp0_flags},  64'd0);
        chk("add_v",   {63'd0, rsp0_valid},  64'd1);
        set0(1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
        cycle();
        chk("add_v_drop", {63'd0, rsp0_valid}, 64'd0);

        // private flags on requester 1
        set1(1'b1, 32'd3, 32'd3, 2'b01, 1'b1);
        cycle();
        chk("sub_res", {32'd0, rsp1_result}, 64'd0);
        chk("sub_fl",  {60'd0, rsp1_flags},  64'h6);
        chk("sub_fl0", {60'd0, rsp0_flags},  64'h0);
        set1(1'b1, 32'd1, 32'd2, 2'b01, 1'b0);
        cycle();
        chk("sub2_res", {32'd0, rsp1_result}, 64'hFFFF_FFFF);
        chk("sub2_fl",  {60'd0, rsp1_flags},  64'h6);

        // contention: strict alternation starting with requester 0
        set0(1'b1, 32'd7, 32'd9, 2'b00, 1'b0);
        set1(1'b1, 32'd7, 32'd9, 2'b11, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            exp_g = i % 2;
            chk("cont_grant", 64'(last_g), 64'(exp_g));
        end

        // backpressure on requester 0
        rsp0_ready = 1'b0;
        set0(1'b1, 32'd10, 32'd20, 2'b00, 1'b1);
        cycle();
        chk("bp_first", 64'(last_g), 64'd0);
        set0(1'b1, 32'd100, 32'd1, 2'b01, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_grant1", 64'(last_g), 64'd1);
            chk("bp_hold", {32'd0, rsp0_result}, 64'd30);
        end
        rsp0_ready = 1'b1;
        cycle();
        chk("bp_release", 64'(last_g), 64'd0);
        chk("bp_valid",   {63'd0, rsp0_valid}, 64'd1);
        chk("bp_res",     {32'd0, rsp0_result}, 64'd99);

        // signed overflow and logic op
        set1(1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
        set0(1'b1, 32'h7FFF_FFFF, 32'd1, 2'b00, 1'b1);
        cycle();
        chk("ovf_res", {32'd0, rsp0_result}, 64'h8000_0000);
        chk("ovf_fl",  {60'd0, rsp0_flags},  64'h9);
        set0(1'b1, 32'hF0, 32'h3C, 2'b10, 1'b1);
        cycle();
        chk("and_res", {32'd0, rsp0_result}, 64'h30);
        chk("and_fl",  {60'd0, rsp0_flags},  64'h0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            set0(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 2'($urandom), 1'($urandom));
            set1(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 2'($urandom), 1'($urandom));
            if ((i % 8) == 0) begin
                req0_a = 32'h7FFF_FFFF;
                req1_b = req1_a;
            end
            rsp0_ready = 1'($urandom_range(0, 2) != 0);
            rsp1_ready = 1'($urandom_range(0, 2) != 0);
            cycle();
        end

        // reset mid-stream with rsp1 full and both requests pending
        rsp0_ready = 1'b1; rsp1_ready = 1'b0;
        set0(1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
        set1(1'b1, 32'd3, 32'd3, 2'b01, 1'b1);
        cycle();
        chk("mid_v1", {63'd0, rsp1_valid}, 64'd1);
        set0(1'b1, 32'd4, 32'd4, 2'b00, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("mid_v0",   {63'd0, rsp0_valid}, 64'd0);
        chk("mid_v1c",  {63'd0, rsp1_valid}, 64'd0);
        chk("mid_fl1",  {60'd0, rsp1_flags}, 64'd0);
        chk("mid_rdy0", {63'd0, req0_ready}, 64'd0);
        chk("mid_rdy1", {63'd0, req1_ready}, 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        rsp1_ready = 1'b1;
        cycle();
        chk("post_rst_tie", 64'(last_g), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
